// File: rtl/led_step_sequencer_if.sv
// Pattern-sequencer bus: tick/enable/mode in, registered LED pattern and step/wrap pulses out.
interface led_step_sequencer_if #(
    parameter int unsigned WIDTH = 8
);
    logic             tick_in;
    logic             enable;
    logic [1:0]       mode;
    logic [WIDTH-1:0] leds;
    logic             step;
    logic             wrap;

    modport master (output tick_in, enable, mode, input leds, step, wrap);
    modport slave  (input tick_in, enable, mode, output leds, step, wrap);
endinterface

// File: rtl/led_step_sequencer.sv
// LED step sequencer: advances a selectable pattern on each rising edge of a slow tick.
// Optional TICK_SYNC_EN adds a 2-flop synchronizer in front of the tick edge detector.
module led_step_sequencer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    led_step_sequencer_if.slave  io_bus
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_leds, w_leds_nxt;
    logic             r_step, w_step_nxt;
    logic             r_wrap, w_wrap_nxt;
    logic             r_dir_up, w_dir_nxt;
    logic [1:0]       r_cur_mode, w_mode_nxt;
    logic             r_tick_prev;
    logic             w_tick_s;
    logic             w_tick_rise;
    logic             w_load;
    logic [WIDTH-1:0] w_init;
    logic [WIDTH-1:0] w_adv;
    logic             w_adv_wrap;
    logic             w_adv_dir;

`ifdef TICK_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_sync <= 2'b00;
        else       r_sync <= {r_sync[0], io_bus.tick_in};
    end

    assign w_tick_s = r_sync[1];
`else
    assign w_tick_s = io_bus.tick_in;
`endif

    assign w_tick_rise = w_tick_s & ~r_tick_prev;

    // Initial pattern for the mode being latched on entry to LOAD.
    always_comb begin
        w_init = WIDTH'(1);
        case (io_bus.mode)
            2'd0:    w_init = '0;
            2'd3:    w_init = '1;
            default: w_init = WIDTH'(1);
        endcase
    end

    // One pattern advance plus its wrap condition and updated bounce direction.
    always_comb begin
        w_adv      = r_leds;
        w_adv_wrap = 1'b0;
        w_adv_dir  = r_dir_up;
        case (r_cur_mode)
            2'd0: begin
                w_adv      = r_leds + WIDTH'(1);
                w_adv_wrap = &r_leds;
            end
            2'd1: begin
                w_adv      = {r_leds[WIDTH-2:0], r_leds[WIDTH-1]};
                w_adv_wrap = r_leds[WIDTH-1];
            end
            2'd2: begin
                if (r_dir_up) begin
                    w_adv     = r_leds << 1;
                    w_adv_dir = ~r_leds[WIDTH-2];
                end else begin
                    w_adv      = r_leds >> 1;
                    w_adv_dir  = r_leds[1];
                    w_adv_wrap = r_leds[1];
                end
            end
            default: begin
                w_adv      = ~r_leds;
                w_adv_wrap = ~|r_leds;
            end
        endcase
    end

    // Next state; RUN priority is disable, then mode change, then tick.
    always_comb begin
        w_state_nxt = r_state;
        w_leds_nxt  = r_leds;
        w_step_nxt  = 1'b0;
        w_wrap_nxt  = 1'b0;
        w_dir_nxt   = r_dir_up;
        w_mode_nxt  = r_cur_mode;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_leds_nxt = '0;
                if (io_bus.enable) w_load = 1'b1;
            end
            S_LOAD: w_state_nxt = S_RUN;
            S_RUN: begin
                if (!io_bus.enable) begin
                    w_state_nxt = S_IDLE;
                    w_leds_nxt  = '0;
                end else if (io_bus.mode != r_cur_mode) begin
                    w_load = 1'b1;
                end else if (w_tick_rise) begin
                    w_leds_nxt = w_adv;
                    w_dir_nxt  = w_adv_dir;
                    w_step_nxt = 1'b1;
                    w_wrap_nxt = w_adv_wrap;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_load) begin
            w_state_nxt = S_LOAD;
            w_leds_nxt  = w_init;
            w_dir_nxt   = 1'b1;
            w_mode_nxt  = io_bus.mode;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_leds      <= '0;
            r_step      <= 1'b0;
            r_wrap      <= 1'b0;
            r_dir_up    <= 1'b0;
            r_cur_mode  <= 2'd0;
            r_tick_prev <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_leds      <= w_leds_nxt;
            r_step      <= w_step_nxt;
            r_wrap      <= w_wrap_nxt;
            r_dir_up    <= w_dir_nxt;
            r_cur_mode  <= w_mode_nxt;
            r_tick_prev <= w_tick_s;
        end
    end

    assign io_bus.leds = r_leds;
    assign io_bus.step = r_step;
    assign io_bus.wrap = r_wrap;

endmodule
